// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for the audio FFT: gathers samples into N-beat SOP/EOP frames for the core
// sink, tags core output beats with a bin index, and tracks frame completion and framing errors.
module fft_frame_ctrl #(
  parameter int unsigned N_LOG2 = 10,
  parameter int unsigned DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic              i_sample_valid,
  input  logic [DATA_W-1:0] i_sample,
  output logic              o_sink_valid,
  output logic              o_sink_sop,
  output logic              o_sink_eop,
  output logic [DATA_W-1:0] o_sink_data,
  input  logic              i_sink_ready,
  input  logic              i_src_valid,
  input  logic              i_src_sop,
  input  logic              i_src_eop,
  output logic              o_bin_valid,
  output logic [N_LOG2-1:0] o_bin_idx,
  output logic              o_frame_done,
  output logic [15:0]       o_frame_cnt,
  output logic [15:0]       o_drop_cnt,
  output logic              o_frame_err
);

  localparam logic [N_LOG2-1:0] LastIdx = '1;

  typedef enum logic [1:0] {StIdle, StFill, StWait} state_e;

  state_e              r_state, w_state_nxt;
  logic                r_hold_valid;
  logic [DATA_W-1:0]   r_hold_data;
  logic [N_LOG2-1:0]   r_in_cnt;
  logic [15:0]         r_drop_cnt;

  logic                r_started;
  logic [N_LOG2-1:0]   r_out_cnt;
  logic                r_bin_valid;
  logic [N_LOG2-1:0]   r_bin_idx;
  logic                r_done;
  logic [15:0]         r_frame_cnt;
  logic                r_err;

  logic                w_accept, w_last_accept, w_load, w_drop, w_src_eop_beat;
  logic [N_LOG2-1:0]   w_out_nxt, w_idx;
  logic                w_err;

  assign w_accept       = r_hold_valid & i_sink_ready;
  assign w_last_accept  = w_accept & (r_in_cnt == LastIdx);
  // A sample arriving as the EOP beat drains belongs to no frame, so it is dropped.
  assign w_load         = i_sample_valid & (r_state == StFill) &
                          (~r_hold_valid | (w_accept & ~w_last_accept));
  assign w_drop         = i_sample_valid & ((r_state == StWait) |
                                            ((r_state == StFill) & ~w_load));
  assign w_src_eop_beat = i_src_valid & i_src_eop;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: if (i_enable) w_state_nxt = StFill;
      StFill: if (w_last_accept) w_state_nxt = StWait;
      StWait: if (w_src_eop_beat) w_state_nxt = i_enable ? StFill : StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_hold_valid <= 1'b0;
      r_hold_data  <= '0;
      r_in_cnt     <= '0;
      r_drop_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_hold_valid <= 1'b1;
        r_hold_data  <= i_sample;
      end else if (w_accept) begin
        r_hold_valid <= 1'b0;
      end
      if (w_accept) r_in_cnt <= r_in_cnt + 1'b1;
      if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign o_sink_valid = r_hold_valid;
  assign o_sink_data  = r_hold_data;
  assign o_sink_sop   = r_hold_valid & (r_in_cnt == '0);
  assign o_sink_eop   = r_hold_valid & (r_in_cnt == LastIdx);
  assign o_drop_cnt   = r_drop_cnt;

  // r_out_cnt holds the index of the previous output beat; beats outside a frame tag as 0.
  always_comb begin
    w_out_nxt = r_out_cnt + 1'b1;
    w_idx     = (i_src_sop || !r_started) ? '0 : w_out_nxt;
    w_err     = i_src_valid & ((i_src_sop & r_started & (w_out_nxt != '0)) |
                               (~i_src_sop & ~r_started) |
                               (i_src_eop & (w_idx != LastIdx)));
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_started   <= 1'b0;
      r_out_cnt   <= '0;
      r_bin_valid <= 1'b0;
      r_bin_idx   <= '0;
      r_done      <= 1'b0;
      r_frame_cnt <= '0;
      r_err       <= 1'b0;
    end else begin
      r_bin_valid <= i_src_valid;
      r_done      <= w_src_eop_beat;
      if (i_src_valid) begin
        r_bin_idx <= w_idx;
        r_out_cnt <= w_idx;
        r_started <= ~i_src_eop;
      end
      if (w_src_eop_beat && (w_idx == LastIdx)) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_err) r_err <= 1'b1;
    end
  end

  assign o_bin_valid  = r_bin_valid;
  assign o_bin_idx    = r_bin_idx;
  assign o_frame_done = r_done;
  assign o_frame_cnt  = r_frame_cnt;
  assign o_frame_err  = r_err;

endmodule
